// File: rtl/axis_mux_n1_pkt.sv
// Packet-aware N:1 AXI-Stream mux with a single registered output stage.
// Optional build macro AXIS_MUX_RR_ARB_EN replaces sel with round-robin arbitration.
module axis_mux_n1_pkt #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH-1:0]        s_last,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [SEL_W-1:0]         active_ch,
  output logic                     busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                ld, grant_ok, accept, valid_g, last_g;
  logic [SEL_W-1:0]    g;
  logic [DATA_W-1:0]   data_g;
  logic [DATA_W-1:0]   m_data_nxt;
  logic                m_valid_nxt, m_last_nxt, busy_nxt;
  logic [SEL_W-1:0]    active_ch_nxt;

  assign ld = !m_valid || m_ready;

`ifdef AXIS_MUX_RR_ARB_EN
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;

  // Round-robin search from the channel after the last completed packet.
  always_comb begin : grant_sel
    g        = active_ch;
    grant_ok = 1'b0;
    if (state == LOCKED) begin
      grant_ok = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (!grant_ok && s_valid[k] && (k == ((32'(rr_ptr) + i) % NUM_CH))) begin
            g        = SEL_W'(k);
            grant_ok = 1'b1;
          end
        end
      end
    end
  end
`else
  // IDLE follows sel directly; out-of-range sel yields no grant.
  always_comb begin : grant_sel
    g        = active_ch;
    grant_ok = 1'b0;
    if (state == LOCKED) begin
      grant_ok = 1'b1;
    end else begin
      g        = sel;
      grant_ok = (32'(sel) < NUM_CH);
    end
  end
`endif

  // Route the granted channel and drive its ready from the load enable.
  always_comb begin : route
    data_g  = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    s_ready = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_ok && (32'(g) == k)) begin
        data_g     = s_data[k*DATA_W +: DATA_W];
        valid_g    = s_valid[k];
        last_g     = s_last[k];
        s_ready[k] = ld;
      end
    end
  end

  assign accept = grant_ok && valid_g && ld;

  always_comb begin : next_state
    state_nxt     = state;
    m_valid_nxt   = m_valid;
    m_data_nxt    = m_data;
    m_last_nxt    = m_last;
    active_ch_nxt = active_ch;
`ifdef AXIS_MUX_RR_ARB_EN
    rr_ptr_nxt    = rr_ptr;
`endif
    if (ld) begin
      m_valid_nxt = accept;
    end
    if (accept) begin
      m_data_nxt    = data_g;
      m_last_nxt    = last_g;
      active_ch_nxt = g;
      if (state == IDLE) begin
        if (!last_g) state_nxt = LOCKED;
      end else begin
        if (last_g) state_nxt = IDLE;
      end
`ifdef AXIS_MUX_RR_ARB_EN
      if (last_g) rr_ptr_nxt = g;
`endif
    end
    busy_nxt = (state_nxt == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin : regs
    if (!reset) begin
      state     <= IDLE;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      active_ch <= '0;
      busy      <= 1'b0;
`ifdef AXIS_MUX_RR_ARB_EN
      rr_ptr    <= SEL_W'(NUM_CH - 1);
`endif
    end else begin
      state     <= state_nxt;
      m_valid   <= m_valid_nxt;
      m_data    <= m_data_nxt;
      m_last    <= m_last_nxt;
      active_ch <= active_ch_nxt;
      busy      <= busy_nxt;
`ifdef AXIS_MUX_RR_ARB_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
    end
  end

endmodule

// File: doc/axis_mux_n1_pkt.md
Name: axis_mux_n1_pkt

Overview:
- Parametrised N:1 AXI-Stream multiplexer; successor to the 2:1 stream mux.
- Routes one of NUM_CH slave streams to a single master stream through a registered output stage.
- Switching is packet-aware: a channel change takes effect only at a packet boundary, after an accepted beat with s_last=1.
- Sits between multiple packet producers and one downstream consumer.

Parameters:
- NUM_CH, 4, number of slave channels (2..16).
- DATA_W, 8, data width per channel in bits.
- SEL_W, 2, width of sel; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sel  in  SEL_W  requested channel; sampled only while IDLE.
- s_data  in  NUM_CH*DATA_W  channel k data at bits [k*DATA_W +: DATA_W].
- s_valid  in  NUM_CH  per-channel valid.
- s_ready  out  NUM_CH  per-channel ready.
- s_last  in  NUM_CH  per-channel end-of-packet.
- m_data  out  DATA_W  output data, registered.
- m_valid  out  1  output valid, registered.
- m_ready  in  1  downstream ready.
- m_last  out  1  output end-of-packet, registered.
- active_ch  out  SEL_W  currently granted channel.
- busy  out  1  high while mid-packet (LOCKED state).

Behaviour:
- Reset (reset=0, asynchronous): m_valid=0, m_data=0, m_last=0, active_ch=0, busy=0, state=IDLE.
- Output stage is a single register. Its load enable is ld = !m_valid || m_ready.
- Grant channel g:
  - IDLE: g = sel (combinational).
  - LOCKED: g = the latched active_ch.
- s_ready[g] = ld. All other s_ready bits are 0.
- If sel >= NUM_CH while IDLE, there is no grant: all s_ready=0 and no beat is accepted.
- A beat is accepted when s_valid[g] && s_ready[g]. The output register then loads s_data[g] and s_last[g], and m_valid=1 on the next cycle.
- Latency: 1 cycle from accept to m_valid.
- If ld && no accept: m_valid goes to 0 and m_data/m_last hold their values.
- Throughput is 1 beat/cycle while m_ready=1. The ready path from m_ready to s_ready is combinational.
- active_ch updates to g on every accept.
- State machine:
  - IDLE -> LOCKED on an accepted beat with s_last[g]=0; busy=1 from the next cycle.
  - LOCKED -> IDLE on an accepted beat with s_last[g]=1; busy=0 from the next cycle.
  - IDLE stays IDLE on an accepted beat with s_last=1 (single-beat packet).
- sel changes while LOCKED are ignored. The new sel takes effect in the first IDLE cycle.
- Non-granted channels see s_ready=0 and must hold their beats (AXI rule). The mux never drops or duplicates a beat.
- m_valid, once high, stays high with m_data/m_last stable until m_ready=1.
- Reset asserted mid-packet: immediate return to IDLE with outputs cleared. A partial packet is truncated with no m_last; the upstream side is responsible.

Optional Feature:
- Macro: AXIS_MUX_RR_ARB_EN.
- Defined:
  - sel is ignored.
  - In IDLE, g is chosen by round-robin among channels with s_valid=1, starting from (last granted + 1) mod NUM_CH.
  - If no channel is valid, g holds the previous value and all s_ready=0.
  - The round-robin pointer advances only when a packet completes (LOCKED->IDLE, or a single-beat packet is accepted in IDLE).
  - The pointer resets to NUM_CH-1, so channel 0 is granted first.
- Not defined: sel-driven behaviour as specified above.

Test Plan:
- Reset/idle: reset=0 for 2 cycles, then 1, with all s_valid=0 -> m_valid=0, busy=0, active_ch=0, s_ready=0000 on non-selected channels.
- Mid-packet sel change: sel=1, ch1 sends a 4-beat packet 0x11,0x22,0x33,0x44(last) with m_ready=1; sel=2 at beat 2 -> all 4 beats appear on m_data one cycle after accept, m_last only with 0x44, then the ch2 beat 0xA0 follows with no gap.
- Backpressure: ch0 streams 0x01..0x06 with m_ready pattern 1,1,0,0,1,1,1,0,1 -> output order 0x01..0x06 exactly, no loss or duplication, m_data stable while m_valid=1 && m_ready=0.
- Invalid sel: NUM_CH=3, sel=3, ch0..ch2 valid -> all s_ready=0 and m_valid=0 throughout; sel=0 -> ch0 accepted next cycle.
- Single-beat packets: sel alternates 0,1 every cycle; ch0 sends 0x5A(last), ch1 sends 0xC3(last) -> busy stays 0 and the outputs alternate 0x5A, 0xC3.
- AXIS_MUX_RR_ARB_EN defined: all 4 channels continuously send 2-beat packets -> grant order 0,1,2,3,0; with only ch2 valid -> ch2 is granted back-to-back.
